// File: rtl/pong_game_ctrl_if.sv
// Board-side signal bundle of the pong game-flow controller: raw buttons and
// ball-miss events in, state/ball controls/scores/debug LEDs out.
interface pong_game_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               btnC, btnU, btnD, btnL, btnR;
    logic               miss_l, miss_r;
    logic [2:0]         state;
    logic               ball_rst, serve, serve_dir, play_en;
    logic [SCORE_W-1:0] score_l, score_r, win_score;
    logic               winner;
    logic [5:0]         led;

    modport master (
        output btnC, btnU, btnD, btnL, btnR, miss_l, miss_r,
        input  state, ball_rst, serve, serve_dir, play_en,
        input  score_l, score_r, win_score, winner, led
    );

    modport slave (
        input  btnC, btnU, btnD, btnL, btnR, miss_l, miss_r,
        output state, ball_rst, serve, serve_dir, play_en,
        output score_l, score_r, win_score, winner, led
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: button conditioning, menu/set/serve/play/point/over/pause FSM,
// scores and win-score setting. Optional PONG_DEBOUNCE_EN adds a per-button debouncer.
module pong_game_ctrl #(
    parameter int SCORE_W     = 4,
    parameter int WIN_DEFAULT = 5,
    parameter int WIN_MAX     = 9,
    parameter int POINT_HOLD  = 100000000,
    parameter int DEB_CYCLES  = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    pong_game_ctrl_if.slave io_game
);
    localparam int                 TW        = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_HI    = SCORE_W'(WIN_MAX);
    localparam logic [SCORE_W-1:0] WIN_LO    = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] WIN_RST   = SCORE_W'(WIN_DEFAULT);
    localparam logic [TW-1:0]      HOLD_LAST = TW'(POINT_HOLD - 1);

    if ((WIN_MAX > (2**SCORE_W) - 1) || (WIN_DEFAULT < 1) || (WIN_DEFAULT > WIN_MAX) ||
        (POINT_HOLD < 1) || (DEB_CYCLES < 1)) begin : g_bad_params
        $error("pong_game_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_MENU  = 3'd0,
        S_SET   = 3'd1,
        S_SERVE = 3'd2,
        S_PLAY  = 3'd3,
        S_POINT = 3'd4,
        S_OVER  = 3'd5,
        S_PAUSE = 3'd6
    } state_t;

    // Button bit order: 0=C 1=U 2=D 3=L 4=R
    logic [4:0] w_btn_raw, w_lvl;
    logic [4:0] r_sync1, r_sync2, r_lvl_d, r_press;
    logic       w_p_c, w_p_u, w_p_d, w_p_l, w_p_r;

    assign w_btn_raw = {io_game.btnR, io_game.btnL, io_game.btnD, io_game.btnU, io_game.btnC};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl_d <= '0;
            r_press <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_lvl_d <= w_lvl;
            r_press <= w_lvl & ~r_lvl_d;
        end
    end

`ifdef PONG_DEBOUNCE_EN
    localparam int            DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [4:0]         r_deb;
    logic [4:0][DW-1:0] r_deb_cnt;

    // Counter runs only while the input disagrees with the accepted level; any bounce restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb     <= '0;
            r_deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_lvl = r_deb;
`else
    assign w_lvl = r_sync2;
`endif

    assign w_p_c = r_press[0];
    assign w_p_u = r_press[1];
    assign w_p_d = r_press[2];
    assign w_p_l = r_press[3];
    assign w_p_r = r_press[4];

    state_t             r_state, w_state_nx;
    logic [SCORE_W-1:0] r_score_l, r_score_r, r_win;
    logic [SCORE_W-1:0] w_score_l_nx, w_score_r_nx, w_win_nx;
    logic [TW-1:0]      r_timer, w_timer_nx;
    logic               r_dir, r_winner, r_ball_rst, r_serve, r_play_en;
    logic               w_dir_nx, w_winner_nx, w_ball_rst_nx, w_serve_nx, w_play_en_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_MENU;
            r_score_l  <= '0;
            r_score_r  <= '0;
            r_win      <= WIN_RST;
            r_timer    <= '0;
            r_dir      <= 1'b0;
            r_winner   <= 1'b0;
            r_ball_rst <= 1'b0;
            r_serve    <= 1'b0;
            r_play_en  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_score_l  <= w_score_l_nx;
            r_score_r  <= w_score_r_nx;
            r_win      <= w_win_nx;
            r_timer    <= w_timer_nx;
            r_dir      <= w_dir_nx;
            r_winner   <= w_winner_nx;
            r_ball_rst <= w_ball_rst_nx;
            r_serve    <= w_serve_nx;
            r_play_en  <= w_play_en_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_score_l_nx  = r_score_l;
        w_score_r_nx  = r_score_r;
        w_win_nx      = r_win;
        w_timer_nx    = r_timer;
        w_dir_nx      = r_dir;
        w_winner_nx   = r_winner;
        w_ball_rst_nx = 1'b0;
        w_serve_nx    = 1'b0;

        // L aborts to MENU ahead of every other event in the same cycle.
        if (w_p_l && (r_state != S_MENU)) begin
            w_state_nx    = S_MENU;
            w_score_l_nx  = '0;
            w_score_r_nx  = '0;
            w_timer_nx    = '0;
            w_ball_rst_nx = 1'b1;
        end else begin
            case (r_state)
                S_MENU: if (w_p_c) w_state_nx = S_SET;
                S_SET: begin
                    if (w_p_u && !w_p_d && (r_win < WIN_HI))
                        w_win_nx = r_win + 1'b1;
                    else if (w_p_d && !w_p_u && (r_win > WIN_LO))
                        w_win_nx = r_win - 1'b1;
                    if (w_p_c) begin
                        w_state_nx    = S_SERVE;
                        w_score_l_nx  = '0;
                        w_score_r_nx  = '0;
                        w_dir_nx      = 1'b0;
                        w_ball_rst_nx = 1'b1;
                    end
                end
                S_SERVE: begin
                    if (w_p_c) begin
                        w_state_nx = S_PLAY;
                        w_serve_nx = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (io_game.miss_l && io_game.miss_r) begin
                        w_dir_nx   = ~r_dir;
                        w_state_nx = S_POINT;
                    end else if (io_game.miss_l) begin
                        w_score_r_nx = (r_score_r == SCORE_MAX) ? r_score_r : r_score_r + 1'b1;
                        w_dir_nx     = 1'b0;
                        w_state_nx   = S_POINT;
                    end else if (io_game.miss_r) begin
                        w_score_l_nx = (r_score_l == SCORE_MAX) ? r_score_l : r_score_l + 1'b1;
                        w_dir_nx     = 1'b1;
                        w_state_nx   = S_POINT;
                    end else if (w_p_r) begin
                        w_state_nx = S_PAUSE;
                    end
                end
                S_PAUSE: if (w_p_r) w_state_nx = S_PLAY;
                S_POINT: begin
                    if (r_timer == HOLD_LAST) begin
                        w_timer_nx = '0;
                        if (r_score_l == r_win) begin
                            w_state_nx  = S_OVER;
                            w_winner_nx = 1'b0;
                        end else if (r_score_r == r_win) begin
                            w_state_nx  = S_OVER;
                            w_winner_nx = 1'b1;
                        end else begin
                            w_state_nx    = S_SERVE;
                            w_ball_rst_nx = 1'b1;
                        end
                    end else begin
                        w_timer_nx = r_timer + 1'b1;
                    end
                end
                S_OVER: if (w_p_c) w_state_nx = S_MENU;
                default: w_state_nx = S_MENU;
            endcase
        end

        w_play_en_nx = (w_state_nx == S_PLAY);
    end

    assign io_game.state     = r_state;
    assign io_game.ball_rst  = r_ball_rst;
    assign io_game.serve     = r_serve;
    assign io_game.serve_dir = r_dir;
    assign io_game.play_en   = r_play_en;
    assign io_game.score_l   = r_score_l;
    assign io_game.score_r   = r_score_r;
    assign io_game.win_score = r_win;
    assign io_game.winner    = r_winner;
    assign io_game.led       = {|r_sync2, r_winner, r_play_en, r_state};
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game flows plus random button/miss
// traffic, checked every cycle against a behavioural game model.
module tb_pong_game_ctrl;
    localparam int SW   = 4;
    localparam int HOLD = 4;
    localparam int MENU = 0, SET = 1, SERVE = 2, PLAY = 3, POINT = 4, OVER = 5, PAUSE = 6;
    localparam int BC = 0, BU = 1, BD = 2, BL = 3, BR = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] btn = '0;
    logic       ml = 1'b0, mr = 1'b0;

    pong_game_ctrl_if #(.SCORE_W(SW)) ifc();
    assign ifc.btnC   = btn[BC];
    assign ifc.btnU   = btn[BU];
    assign ifc.btnD   = btn[BD];
    assign ifc.btnL   = btn[BL];
    assign ifc.btnR   = btn[BR];
    assign ifc.miss_l = ml;
    assign ifc.miss_r = mr;

    pong_game_ctrl #(
        .SCORE_W(SW), .WIN_DEFAULT(5), .WIN_MAX(9), .POINT_HOLD(HOLD), .DEB_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_game (ifc)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Game model: a press is seen by the game 3 sampled edges after the raw level first rises.
    int         m_state, m_sl, m_sr, m_win, m_timer;
    bit         m_dir, m_winner, m_brst, m_serve, m_pen, m_led5;
    logic [3:0] hist [5];

    task automatic model_reset();
        m_state = MENU; m_sl = 0; m_sr = 0; m_win = 5; m_timer = 0;
        m_dir = 0; m_winner = 0; m_brst = 0; m_serve = 0; m_pen = 0; m_led5 = 0;
        for (int b = 0; b < 5; b++) hist[b] = '0;
    endtask

    task automatic model_step();
        bit p [5];
        if (rst) begin
            model_reset();
            return;
        end
        for (int b = 0; b < 5; b++) p[b] = hist[b][2] & ~hist[b][3];
        m_brst = 0;
        m_serve = 0;
        if (p[BL] && m_state != MENU) begin
            m_state = MENU; m_sl = 0; m_sr = 0; m_timer = 0; m_brst = 1;
        end else begin
            case (m_state)
                MENU: if (p[BC]) m_state = SET;
                SET: begin
                    if (p[BU] && !p[BD]) m_win = (m_win + 1 > 9) ? 9 : m_win + 1;
                    if (p[BD] && !p[BU]) m_win = (m_win - 1 < 1) ? 1 : m_win - 1;
                    if (p[BC]) begin m_state = SERVE; m_sl = 0; m_sr = 0; m_dir = 0; m_brst = 1; end
                end
                SERVE: if (p[BC]) begin m_state = PLAY; m_serve = 1; end
                PLAY: begin
                    if (ml && mr) begin m_dir = ~m_dir; m_state = POINT; end
                    else if (ml) begin m_sr = (m_sr == 15) ? 15 : m_sr + 1; m_dir = 0; m_state = POINT; end
                    else if (mr) begin m_sl = (m_sl == 15) ? 15 : m_sl + 1; m_dir = 1; m_state = POINT; end
                    else if (p[BR]) m_state = PAUSE;
                end
                PAUSE: if (p[BR]) m_state = PLAY;
                POINT: begin
                    if (m_timer == HOLD - 1) begin
                        m_timer = 0;
                        if (m_sl == m_win) begin m_state = OVER; m_winner = 0; end
                        else if (m_sr == m_win) begin m_state = OVER; m_winner = 1; end
                        else begin m_state = SERVE; m_brst = 1; end
                    end else m_timer++;
                end
                OVER: if (p[BC]) m_state = MENU;
                default: m_state = MENU;
            endcase
        end
        m_pen = (m_state == PLAY);
        m_led5 = 0;
        for (int b = 0; b < 5; b++) begin
            hist[b] = {hist[b][2:0], btn[b]};
            m_led5 |= hist[b][1];
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("state",     int'(ifc.state),     m_state);
            chk("ball_rst",  int'(ifc.ball_rst),  int'(m_brst));
            chk("serve",     int'(ifc.serve),     int'(m_serve));
            chk("serve_dir", int'(ifc.serve_dir), int'(m_dir));
            chk("play_en",   int'(ifc.play_en),   int'(m_pen));
            chk("score_l",   int'(ifc.score_l),   m_sl);
            chk("score_r",   int'(ifc.score_r),   m_sr);
            chk("win_score", int'(ifc.win_score), m_win);
            chk("winner",    int'(ifc.winner),    int'(m_winner));
            chk("led",       int'(ifc.led),
                (int'(m_led5) << 5) | (int'(m_winner) << 4) | (int'(m_pen) << 3) | m_state);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_step();
        end
    endtask

    task automatic press(input logic [4:0] m);
        btn = btn | m;
        tick(4);
        btn = btn & ~m;
        tick(4);
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        ml = l;
        mr = r;
        tick(1);
        ml = 1'b0;
        mr = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        model_reset();
        tick(2);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_state", int'(ifc.state), 0);
        chk("rst_win", int'(ifc.win_score), 5);
        chk("rst_scores", int'(ifc.score_l) + int'(ifc.score_r), 0);

        press(5'b00001); chk("menu_to_set", int'(ifc.state), SET);
        press(5'b00001); chk("set_to_serve", int'(ifc.state), SERVE);
        press(5'b01000); chk("abort_serve", int'(ifc.state), MENU);
        press(5'b00001);
        repeat (6) press(5'b00010);
        chk("win_sat_hi", int'(ifc.win_score), 9);
        repeat (9) press(5'b00100);
        chk("win_sat_lo", int'(ifc.win_score), 1);
        press(5'b00110); chk("win_ud_same", int'(ifc.win_score), 1);
        press(5'b00010); chk("win_two", int'(ifc.win_score), 2);
        press(5'b00001); chk("serve_state", int'(ifc.state), SERVE);
        press(5'b00001); chk("play_en_on", int'(ifc.play_en), 1);

        pulse_miss(0, 1);
        chk("score_l_1", int'(ifc.score_l), 1);
        tick(3); chk("point_hold_end", int'(ifc.state), POINT);
        tick(1); chk("point_to_serve", int'(ifc.state), SERVE);
        press(5'b00001);
        pulse_miss(0, 1);
        tick(4);
        chk("over_state", int'(ifc.state), OVER);
        chk("over_winner", int'(ifc.winner), 0);
        chk("over_led", int'(ifc.led[2:0]), 5);

        press(5'b00001); chk("over_to_menu", int'(ifc.state), MENU);
        press(5'b00001); press(5'b00001); press(5'b00001);
        pulse_miss(1, 1);
        chk("let_state", int'(ifc.state), POINT);
        chk("let_scores", int'(ifc.score_l) + int'(ifc.score_r), 0);
        chk("let_dir", int'(ifc.serve_dir), 1);
        tick(4);
        press(5'b00001);
        btn[BR] = 1'b1;
        tick(3);
        ml = 1'b1;
        tick(1);
        ml = 1'b0;
        chk("miss_beats_r", int'(ifc.state), POINT);
        chk("miss_beats_r_sr", int'(ifc.score_r), 1);
        tick(1);
        btn[BR] = 1'b0;
        tick(3);
        press(5'b00001);
        press(5'b10000);
        chk("pause_state", int'(ifc.state), PAUSE);
        chk("pause_play_en", int'(ifc.play_en), 0);
        pulse_miss(1, 0);
        chk("pause_miss_ign", int'(ifc.score_r), 1);
        press(5'b10000); chk("resume_play", int'(ifc.state), PLAY);

        btn[BL] = 1'b1;
        ml = 1'b1;
        tick(1);
        ml = 1'b0;
        tick(3);
        chk("abort_point", int'(ifc.state), MENU);
        chk("abort_scores", int'(ifc.score_l) + int'(ifc.score_r), 0);
        chk("abort_win_kept", int'(ifc.win_score), 2);
        btn[BL] = 1'b0;
        tick(4);

        press(5'b00001); press(5'b00001); press(5'b00001);
        pulse_miss(0, 1);
        tick(1);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", int'(ifc.state), MENU);
        chk("arst_win", int'(ifc.win_score), 5);
        chk("arst_score_l", int'(ifc.score_l), 0);
        chk("arst_play_en", int'(ifc.play_en), 0);
        model_reset();
        tick(2);
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 999) < ((b == BL) ? 8 : 90)) btn[b] = ~btn[b];
            ml = ($urandom_range(0, 99) < 4);
            mr = ($urandom_range(0, 99) < 4);
            tick(1);
        end
        ml = 1'b0;
        mr = 1'b0;
        btn = '0;
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game-flow sequencer for the Basys3 pong game. Conditions the five push buttons, runs the menu/set/serve/play/point/game-over state machine, and keeps both scores and the winning-score setting. Drives the ball datapath with serve, reset and enable controls, and consumes its miss events. Mirrors the game state onto LEDs for bring-up.

Parameters:
SCORE_W, 4, width of score and win_score registers
WIN_DEFAULT, 5, win_score after reset
WIN_MAX, 9, upper limit for win_score; lower limit is fixed at 1
POINT_HOLD, 100000000, cycles spent in POINT before the next serve (1 s at 100 MHz)
DEB_CYCLES, 1000000, debounce stability window in cycles (only used with DEBOUNCE_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btnC btnU btnD btnL btnR  in  1 each  raw, asynchronous push buttons
miss_l  in  1  single-cycle pulse: ball passed the left paddle (point to right player)
miss_r  in  1  single-cycle pulse: ball passed the right paddle (point to left player)
state  out  3  current state encoding
ball_rst  out  1  one-cycle pulse: re-centre the ball
serve  out  1  one-cycle pulse: launch the ball
serve_dir  out  1  0 = serve toward left, 1 = serve toward right
play_en  out  1  level: ball/paddle motion enabled
score_l, score_r  out  SCORE_W  player scores
win_score  out  SCORE_W  points needed to win
winner  out  1  0 = left won, 1 = right won; valid in OVER
led  out  6  debug: [2:0]=state, [3]=play_en, [4]=winner, [5]=OR of synchronized button levels

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = MENU.
  - score_l = score_r = 0; win_score = WIN_DEFAULT.
  - serve_dir, winner, ball_rst, serve, play_en = 0.
  - POINT timer = 0; synchronizers and edge registers = 0.
- Button conditioning:
  - Each button passes through a 2-flop synchronizer, then a registered rising-edge detector.
  - The resulting press pulse is high for exactly 1 cycle, 3 clk edges after the raw input is first sampled high.
  - Holding a button generates no further pulses.
- State encoding: MENU=0, SET=1, SERVE=2, PLAY=3, POINT=4, OVER=5, PAUSE=6.
- Transitions (all outputs registered):
  - MENU: C press -> SET.
  - SET:
    - U press -> win_score+1, saturating at WIN_MAX.
    - D press -> win_score-1, saturating at 1.
    - U and D pressed in the same cycle -> no change.
    - C press -> SERVE; score_l = score_r = 0; serve_dir = 0.
  - SERVE:
    - Entering SERVE pulses ball_rst for 1 cycle; play_en = 0.
    - C press -> PLAY; serve pulses high in the first PLAY cycle.
  - PLAY: play_en = 1.
    - miss_l alone -> score_r+1, serve_dir = 0, go to POINT.
    - miss_r alone -> score_l+1, serve_dir = 1, go to POINT.
    - miss_l and miss_r in the same cycle -> treated as a let: no score change, serve_dir toggles, go to POINT.
    - R press -> PAUSE. A miss in the same cycle wins over the R press.
  - PAUSE: play_en = 0; R press -> PLAY with no serve pulse.
  - POINT:
    - play_en = 0. The timer counts 0..POINT_HOLD-1, then clears and the state leaves POINT.
    - If score_l == win_score -> OVER, winner = 0.
    - Else if score_r == win_score -> OVER, winner = 1.
    - Else -> SERVE.
    - All buttons are ignored except L.
  - OVER: C press -> MENU. Scores and winner hold until the next SET->SERVE transition.
- Abort: an L press in any state other than MENU -> MENU.
  - Clears scores and the POINT timer; win_score is kept; ball_rst pulses for 1 cycle.
  - Abort has the highest priority over all other events in the same cycle.
- miss_l and miss_r are ignored outside PLAY.
- Scores saturate at 2^SCORE_W-1. An elaboration check requires WIN_MAX <= 2^SCORE_W-1 and 1 <= WIN_DEFAULT <= WIN_MAX.

Optional Feature:
PONG_DEBOUNCE_EN
- Defined: each synchronized button level is debounced before edge detection.
  - The level changes only after the new value has been stable for DEB_CYCLES consecutive cycles; a per-button counter restarts on any bounce.
  - Press latency becomes DEB_CYCLES+3.
- Undefined: the synchronized level goes directly to the edge detector; DEB_CYCLES is unused.

Test Plan:
(All with POINT_HOLD=4, DEBOUNCE undefined.)
- Reset, then C, C -> state 0->1->2; ball_rst pulses 1 cycle on entering 2; win_score=5; scores 0.
- In SET: U pressed 6 times -> win_score=9 (saturated). Then D pressed 9 times -> win_score=1. U and D held together -> no change.
- win_score=2, C to PLAY (serve pulse 1 cycle), then miss_r -> score_l=1, POINT for 4 cycles, SERVE. Repeat -> OVER, winner=0, led[2:0]=5.
- In PLAY: miss_l and miss_r in the same cycle -> scores unchanged, serve_dir toggles, POINT. miss_l together with an R press -> POINT (not PAUSE), score_r+1.
- In PLAY: R -> PAUSE, play_en=0; miss_l ignored; R -> PLAY with no serve pulse. L press in POINT -> MENU, scores 0, win_score kept.
- Assert rst mid-POINT, asynchronously -> all outputs return to reset values immediately; with PONG_DEBOUNCE_EN, a 10-cycle glitch on btnC produces no press.
